// File: rtl/spi_flash_seq_pkg.sv
// Shared types and constants for the SPI flash command sequencer:
// FSM states, command-select codes, flash opcodes and command decode helpers.
package spi_flash_pkg;

  localparam int BUF_BYTES_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_END
  } state_e;

  localparam logic [7:0] CMD_READ = 8'd1;
  localparam logic [7:0] CMD_PP   = 8'd2;
  localparam logic [7:0] CMD_WREN = 8'd3;
  localparam logic [7:0] CMD_SE   = 8'd4;
  localparam logic [7:0] CMD_RDSR = 8'd5;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_SE   = 8'h20;
  localparam logic [7:0] OP_RDSR = 8'h05;

  function automatic logic cmd_valid(input logic [7:0] c);
    return (c >= CMD_READ) && (c <= CMD_RDSR);
  endfunction

  function automatic logic [7:0] cmd_opcode(input logic [7:0] c);
    case (c)
      CMD_READ: return OP_READ;
      CMD_PP:   return OP_PP;
      CMD_WREN: return OP_WREN;
      CMD_SE:   return OP_SE;
      CMD_RDSR: return OP_RDSR;
      default:  return 8'h00;
    endcase
  endfunction

  function automatic logic cmd_has_addr(input logic [7:0] c);
    return (c == CMD_READ) || (c == CMD_PP) || (c == CMD_SE);
  endfunction

  function automatic logic cmd_is_rx(input logic [7:0] c);
    return (c == CMD_READ) || (c == CMD_RDSR);
  endfunction

endpackage

// File: rtl/spi_flash_seq_if.sv
// Register-file side of the sequencer: configuration words in, status and read buffer out.
interface spi_flash_seq_if
  import spi_flash_pkg::*;
#(
  parameter int CMD_W     = 4,
  parameter int BUF_BYTES = BUF_BYTES_DEF
);
  logic [CMD_W-1:0]       i_cmd;
  logic [23:0]            i_addr;
  logic [23:0]            i_len;
  logic [8*BUF_BYTES-1:0] i_wr_data;
  logic [25:0]            i_clk_div;
  logic                   i_start;
  logic                   o_done;
  logic                   o_busy;
  logic                   o_err;
  logic [8*BUF_BYTES-1:0] o_rx_data;

  modport master (
    output i_cmd, i_addr, i_len, i_wr_data, i_clk_div, i_start,
    input  o_done, o_busy, o_err, o_rx_data
  );

  modport slave (
    input  i_cmd, i_addr, i_len, i_wr_data, i_clk_div, i_start,
    output o_done, o_busy, o_err, o_rx_data
  );
endinterface

// File: rtl/spi_flash_seq_shifter.sv
// One-byte SPI mode-0 shifter: divider counting, SCK generation, MSB-first shift out/in.
// A load on the same cycle as byte_done chains the next byte with no gap.
module spi_byte_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic [7:0] div,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       byte_done,
  output logic [7:0] rx_byte
);
  logic       active_q;
  logic       sck_q;
  logic       mosi_q;
  logic [7:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] sh_q;
  logic [7:0] rx_q;
  logic       half_end;

  assign half_end  = (cnt_q == div);
  assign byte_done = active_q & sck_q & half_end & (bit_q == 3'd7);
  assign sck       = sck_q;
  assign mosi      = mosi_q;
  assign rx_byte   = rx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
    end else if (load) begin
      active_q <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= tx_byte[7];
      cnt_q    <= '0;
      bit_q    <= '0;
    end else if (active_q) begin
      if (!half_end) begin
        cnt_q <= cnt_q + 8'd1;
      end else begin
        cnt_q <= '0;
        if (!sck_q) begin
          sck_q <= 1'b1;
        end else begin
          sck_q <= 1'b0;
          if (bit_q == 3'd7) begin
            active_q <= 1'b0;
            mosi_q   <= 1'b0;
          end else begin
            bit_q  <= bit_q + 3'd1;
            mosi_q <= sh_q[6];
          end
        end
      end
    end
  end

  // MISO is captured on the low-to-high SCK transition, so the byte is complete before byte_done.
  always_ff @(posedge clk) begin
    if (load) begin
      sh_q <= tx_byte;
    end else if (active_q && sck_q && half_end) begin
      sh_q <= {sh_q[6:0], 1'b0};
    end
    if (active_q && !sck_q && half_end) begin
      rx_q <= {rx_q[6:0], miso};
    end
  end
endmodule

// File: rtl/spi_flash_seq.sv
// SPI flash command sequencer: turns a register-file command into one mode-0 transaction
// (opcode, optional 3-byte address, optional data phase) and reports done/err/read data.
module spi_flash_seq
  import spi_flash_pkg::*;
#(
  parameter int CMD_W     = 4,
  parameter int BUF_BYTES = BUF_BYTES_DEF
) (
  input  logic           i_clk_ahb,
  input  logic           i_rst,
  spi_flash_seq_if.slave rg,
  output logic           o_cs_n,
  output logic           o_sck,
  output logic           o_mosi,
  input  logic           i_miso
);
  localparam int IDX_W = $clog2(BUF_BYTES + 1);
  localparam int BI_W  = $clog2(BUF_BYTES);

  state_e                 state_q, state_n;
  logic                   start_q, start_rise;
  logic [7:0]             cmd_ext;
  logic [4:0]             len5;
  logic                   accept, reject;
  logic                   cs_n_q, busy_q, done_q, err_q;
  logic [8*BUF_BYTES-1:0] rx_q;
  logic [8*BUF_BYTES-1:0] wr_q;
  logic [23:0]            addr_q;
  logic [7:0]             div_q;
  logic [IDX_W-1:0]       nbytes_q;
  logic                   has_addr_q, rx_dir_q;
  logic [IDX_W-1:0]       idx_q, data_idx;
  logic [7:0]             end_cnt_q;
  logic [7:0]             data_tx;
  logic                   load, byte_done;
  logic [7:0]             tx_byte, rx_byte;
  logic                   unused_bits;

  assign unused_bits = ^{rg.i_len[23:5], rg.i_clk_div[25:8]};

  assign cmd_ext    = 8'(rg.i_cmd);
  assign len5       = rg.i_len[4:0];
  assign start_rise = rg.i_start & ~start_q;
  assign accept     = (state_q == ST_IDLE) && start_rise && cmd_valid(cmd_ext);
  assign reject     = (state_q == ST_IDLE) && start_rise && !cmd_valid(cmd_ext);

  assign data_idx = (state_q == ST_DATA) ? idx_q + IDX_W'(1) : '0;
  assign data_tx  = rx_dir_q ? 8'h00 : wr_q[8*data_idx[BI_W-1:0] +: 8];

  always_ff @(posedge i_clk_ahb) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    load    = 1'b0;
    tx_byte = '0;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        state_n = ST_CMD;
        load    = 1'b1;
        tx_byte = cmd_opcode(cmd_ext);
      end
      ST_CMD: if (byte_done) begin
        if (has_addr_q) begin
          state_n = ST_ADDR;
          load    = 1'b1;
          tx_byte = addr_q[23:16];
        end else if (nbytes_q != '0) begin
          state_n = ST_DATA;
          load    = 1'b1;
          tx_byte = data_tx;
        end else begin
          state_n = ST_END;
        end
      end
      ST_ADDR: if (byte_done) begin
        if (idx_q != IDX_W'(2)) begin
          load    = 1'b1;
          tx_byte = (idx_q == '0) ? addr_q[15:8] : addr_q[7:0];
        end else if (nbytes_q != '0) begin
          state_n = ST_DATA;
          load    = 1'b1;
          tx_byte = data_tx;
        end else begin
          state_n = ST_END;
        end
      end
      ST_DATA: if (byte_done) begin
        if (idx_q == nbytes_q - IDX_W'(1)) begin
          state_n = ST_END;
        end else begin
          load    = 1'b1;
          tx_byte = data_tx;
        end
      end
      ST_END: if (end_cnt_q == div_q) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Status flags, CS and the read buffer; accepting any start clears the previous results.
  always_ff @(posedge i_clk_ahb) begin
    if (i_rst) begin
      start_q <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rx_q    <= '0;
    end else begin
      start_q <= rg.i_start;
      if (accept || reject) begin
        done_q <= reject;
        err_q  <= reject;
        rx_q   <= '0;
      end
      if (accept) begin
        cs_n_q <= 1'b0;
        busy_q <= 1'b1;
      end
      if (state_q == ST_END && state_n == ST_IDLE) begin
        cs_n_q <= 1'b1;
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
      if (state_q == ST_DATA && byte_done && rx_dir_q) begin
        rx_q[8*idx_q[BI_W-1:0] +: 8] <= rx_byte;
      end
    end
  end

  // Command context is frozen at accept so register writes mid-transaction are ignored.
  always_ff @(posedge i_clk_ahb) begin
    if (accept) begin
      addr_q     <= rg.i_addr;
      wr_q       <= rg.i_wr_data;
      div_q      <= rg.i_clk_div[7:0];
      has_addr_q <= cmd_has_addr(cmd_ext);
      rx_dir_q   <= cmd_is_rx(cmd_ext);
      if (cmd_ext == CMD_RDSR) begin
        nbytes_q <= IDX_W'(1);
      end else if (cmd_ext == CMD_READ || cmd_ext == CMD_PP) begin
        nbytes_q <= (len5 > 5'(BUF_BYTES)) ? IDX_W'(BUF_BYTES) : IDX_W'(len5);
      end else begin
        nbytes_q <= '0;
      end
    end
    if (state_n != state_q)  idx_q <= '0;
    else if (byte_done)      idx_q <= idx_q + IDX_W'(1);
    if (state_q != ST_END)   end_cnt_q <= '0;
    else                     end_cnt_q <= end_cnt_q + 8'd1;
  end

  spi_byte_shifter u_shifter (
    .clk       (i_clk_ahb),
    .rst       (i_rst),
    .load      (load),
    .tx_byte   (tx_byte),
    .div       (div_q),
    .miso      (i_miso),
    .sck       (o_sck),
    .mosi      (o_mosi),
    .byte_done (byte_done),
    .rx_byte   (rx_byte)
  );

  assign o_cs_n       = cs_n_q;
  assign rg.o_busy    = busy_q;
  assign rg.o_done    = done_q;
  assign rg.o_err     = err_q;
  assign rg.o_rx_data = rx_q;
endmodule

// File: doc/spi_flash_seq.md
# spi_flash_seq

Command sequencer for the SPI flash controller. It takes the configuration and data words held in the controller's register file (command, address, length, write data, clock divider, start), runs one SPI mode-0 transaction on the flash pins, and returns read data and a done flag for the register file to capture. It sits between the register file and the flash pad ring, in the AHB clock domain.

## Interface
- `CMD_W`, default 4: width of the command-select field.
- `BUF_BYTES`, default 16: size of the data buffer in bytes; the maximum transfer length.
- `i_clk_ahb`  in  1: the only clock.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_cmd`  in  CMD_W: command select, driven from register 0x00 [3:0].
- `i_addr`  in  24: flash byte address, from register 0x04 [23:0].
- `i_len`  in  24: transfer length in bytes, from register 0x08. Only bits [4:0] are used.
- `i_wr_data`  in  128: write buffer, `{reg_18, reg_14, reg_10, reg_0C}`. Byte k is bits [8k+7:8k].
- `i_clk_div`  in  26: SCK divider, from register 0x1C. Only bits [7:0] are used.
- `i_start`  in  1: start level, from register 0x20 [0].
- `o_done`  out  1: completion flag, fed to register 0x24 [0].
- `o_busy`  out  1: high while a transaction is in progress.
- `o_err`  out  1: the last command was invalid.
- `o_rx_data`  out  128: read buffer. Received byte k is at bits [8k+7:8k].
- `o_cs_n`, `o_sck`, `o_mosi`  out  1: flash pins.
- `i_miso`  in  1: flash data in.

## Operation
- **Start detection**
  - A transaction launches on a rising edge of `i_start`, detected against a registered copy, while the block is in IDLE.
  - Start edges during a transaction are dropped, not queued.
- **Command map** (`i_cmd` → opcode / address phase / data phase):
  - 1 → READ 0x03 / addr / rx `len` bytes.
  - 2 → PP 0x02 / addr / tx `len` bytes.
  - 3 → WREN 0x06 / none / none.
  - 4 → SE 0x20 / addr / none.
  - 5 → RDSR 0x05 / none / rx 1 byte.
  - 0 and 6–15 are invalid. The block performs no pin activity, sets `o_err=1` and `o_done=1`, and stays in IDLE.
- **Length**
  - `len = i_len[4:0]`.
  - A value of 0 means the data phase is skipped.
  - Values above 16 are clamped to 16.
- **SPI framing**
  - Mode 0, MSB first; SCK idles low.
  - MOSI is updated at the start of each bit, while SCK is low.
  - MISO is sampled in the cycle SCK rises.
  - Address is sent as 3 bytes, [23:16] first.
  - MOSI is held at 0 during RX bytes.
- **State machine**
  - IDLE → CMD on an accepted start with a valid command.
  - CMD → ADDR if the command has an address phase, else → DATA if it has a data phase, else → END.
  - ADDR → DATA or END, by the same rule.
  - DATA → END after `len` bytes.
  - END → IDLE after one half-period with CS still low.
- **Flag behaviour**
  - Accepting a start clears `o_done`, `o_err` and `o_rx_data` (all cleared, including bytes not written by this transaction).
  - `o_done` is a level that stays high until the next accepted start.

## Timing
- **Reset values:** `o_cs_n=1`, `o_sck=0`, `o_mosi=0`, `o_done=0`, `o_busy=0`, `o_err=0`, `o_rx_data=0`. The state returns to IDLE.
- **Half-period:** `H = i_clk_div[7:0] + 1` clocks. Each bit is SCK low for H clocks, then high for H clocks.
- **Launch:** the start edge is seen on cycle T. On cycle T+1, `o_cs_n=0`, `o_busy=1` and the first MOSI bit is valid.
- **CS low time:** `N·2H + H` clocks, where N is the total number of bits. Examples:
  - WREN: N = 8.
  - READ: N = 32 + 8·len.
- **Completion:** in the cycle `o_cs_n` returns to 1, `o_busy` goes to 0 and `o_done` goes to 1. `o_rx_data` is final on that same cycle.
- **Invalid command:** `o_err` and `o_done` rise on T+1.
- **Divider and inputs:** `i_clk_div` and all command inputs are latched at start. Changing them mid-transaction has no effect.
- **Reset:** reset mid-transaction aborts immediately and gives the reset values on the next cycle (CS deasserts at once). Reset wins over a simultaneous start edge.
- **Start held high:** a start level held high launches exactly one transaction. A new launch needs a 0→1 edge.

## Structure
- **Shared package `spi_flash_pkg`:**
  - State enum.
  - Command-select constants and opcode constants (0x03, 0x02, 0x06, 0x20, 0x05).
  - The `BUF_BYTES` default.
- **Sub-module `spi_byte_shifter`:**
  - Shifts one byte with divider counting and SCK generation.
  - Handshake: `load`/`tx_byte` in; `byte_done`/`rx_byte` out.
  - The parent FSM counts bytes and indexes the buffer.

## Test plan
- **WREN:** `i_cmd=3`, `div=0`, rise start → CS low exactly 17 cycles; MOSI pattern 0x06; `o_done=1`, `o_err=0`.
- **READ:** `i_cmd=1`, `addr=0x123456`, `len=4`, `div=1`, MISO model returns 0xA1 B2 C3 D4 → MOSI 03 12 34 56; `o_rx_data[31:0]=0xD4C3B2A1`; CS low 2·2·64+2 = 258 cycles.
- **PP with clamp:** `i_cmd=2`, `len=20`, `i_wr_data` bytes 0x00..0x0F → MOSI 02, 3 address bytes, then exactly 16 bytes 00..0F.
- **Invalid command:** `i_cmd=0` → no SCK/CS activity; `o_err=1` and `o_done=1` on T+1. A following valid RDSR clears `o_err`.
- **Reset mid-transaction:** assert `i_rst` mid-ADDR → next cycle all outputs are at reset values; a fresh start edge runs a normal RDSR.
- **Start while busy and start held high:**
  - Start toggles during READ → ignored.
  - Start held high after done → no second transaction.
